// File: rtl/reaction_round_ctrl.sv
// Two-player reaction-game round controller: arms a random pre-go delay, lights the go lamp,
// and resolves each round as a reaction, false start, tie or timeout, tracking per-match bests.
module reaction_round_ctrl #(
  parameter int DELAY_MIN = 1000,
  parameter int MAX_COUNT = 999,
  parameter int ROUNDS    = 5
) (
  input  logic        clk,
  input  logic        clear_in,
  input  logic        tick_in,
  input  logic        en,
  input  logic        start_in,
  input  logic        p1_in,
  input  logic        p2_in,
  input  logic [15:0] count_in,
  output logic        cnt_en,
  output logic        cnt_clear,
  output logic        led,
  output logic [15:0] time_out,
  output logic [1:0]  winner,
  output logic [1:0]  foul,
  output logic [15:0] p1_best,
  output logic [15:0] p2_best,
  output logic [2:0]  round_no,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, GO} state_t;

  localparam logic [15:0] MAX_C    = 16'(MAX_COUNT);
  localparam logic [15:0] DMIN_C   = 16'(DELAY_MIN);
  localparam logic [2:0]  ROUNDS_C = 3'(ROUNDS);

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] delay;
  logic        start_q, p1_q, p2_q;
  logic        start_edge, p1_edge, p2_edge, any_press;
  logic        lfsr_fb;
  logic [2:0]  round_next;
  logic        match_end;

  assign start_edge = start_in & ~start_q;
  assign p1_edge    = p1_in & ~p1_q;
  assign p2_edge    = p2_in & ~p2_q;
  assign any_press  = p1_edge | p2_edge;
  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign round_next = round_no + 3'd1;
  assign match_end  = (round_next == ROUNDS_C);

  // Presses are checked before delay expiry so a press on the expiring tick is a false start.
  always_ff @(posedge clk) begin
    if (clear_in) begin
      state     <= IDLE;
      lfsr      <= 16'hACE1;
      delay     <= 16'd0;
      start_q   <= 1'b0;
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      cnt_en    <= 1'b0;
      cnt_clear <= 1'b0;
      led       <= 1'b0;
      time_out  <= 16'd0;
      winner    <= 2'b00;
      foul      <= 2'b00;
      p1_best   <= MAX_C;
      p2_best   <= MAX_C;
      round_no  <= 3'd0;
      done      <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr_fb};
      start_q   <= start_in;
      p1_q      <= p1_in;
      p2_q      <= p2_in;
      cnt_clear <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge && en && (round_no < ROUNDS_C)) begin
            state     <= ARM;
            cnt_clear <= 1'b1;
          end
        end
        ARM: begin
          if (!en) begin
            state <= IDLE;
          end else begin
            winner <= 2'b00;
            foul   <= 2'b00;
            delay  <= DMIN_C + {6'd0, lfsr[9:0]};
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (!en) begin
            state <= IDLE;
          end else if (any_press) begin
            foul     <= {p2_edge, p1_edge};
            winner   <= {p1_edge & ~p2_edge, p2_edge & ~p1_edge};
            time_out <= MAX_C;
            round_no <= round_next;
            done     <= match_end;
            state    <= IDLE;
          end else if ((delay == 16'd0) || (tick_in && (delay == 16'd1))) begin
            led    <= 1'b1;
            cnt_en <= 1'b1;
            state  <= GO;
          end else if (tick_in) begin
            delay <= delay - 16'd1;
          end
        end
        GO: begin
          if (!en) begin
            led    <= 1'b0;
            cnt_en <= 1'b0;
            state  <= IDLE;
          end else if (any_press) begin
            time_out <= count_in;
            winner   <= {p2_edge, p1_edge};
            if (p1_edge && (count_in < p1_best)) p1_best <= count_in;
            if (p2_edge && (count_in < p2_best)) p2_best <= count_in;
            round_no <= round_next;
            done     <= match_end;
            led      <= 1'b0;
            cnt_en   <= 1'b0;
            state    <= IDLE;
          end else if (count_in >= MAX_C) begin
            time_out <= MAX_C;
            winner   <= 2'b00;
            round_no <= round_next;
            done     <= match_end;
            led      <= 1'b0;
            cnt_en   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
